// File: rtl/funnel_pkg.sv
// Shared definitions for the 2:1 funnel / unfunnel pair.
package funnel_pkg;

  // Bit of the configuration word that selects pass or pack
  localparam int unsigned MODE_PACK_BIT = 0;

  typedef enum logic {
    FUN_PASS = 1'b0,
    FUN_PACK = 1'b1
  } fun_mode_e;

endpackage

// File: rtl/unfunnel_oreg.sv
// Single-entry registered req/ack slice carrying {last, half, dat}.
module unfunnel_oreg #(
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [DW-1:0] ld_dat,
  input  logic          ld_last,
  input  logic          ld_half,
  input  logic          ack,
  output logic          req,
  output logic [DW-1:0] dat,
  output logic          last,
  output logic          half,
  output logic          oreg_can_take
);

  // Free when empty or being drained this cycle
  assign oreg_can_take = ~req | ack;

  // Slice register: a load wins over an unload so back-to-back words flow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req  <= 1'b0;
      dat  <= '0;
      last <= 1'b0;
      half <= 1'b0;
    end else if (load) begin
      req  <= 1'b1;
      dat  <= ld_dat;
      last <= ld_last;
      half <= ld_half;
    end else if (ack) begin
      req  <= 1'b0;
    end
  end

endmodule

// File: rtl/unfunnel_1_2.sv
// Packs WIDTH-bit beats into 2*WIDTH words (pack mode) or forwards them as
// half words (pass mode); flushes a held low beat when reconfiguration waits.
module unfunnel_1_2
  import funnel_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               t_0_req,
  output logic               t_0_ack,
  input  logic [WIDTH-1:0]   t_0_dat,
  input  logic               t_0_last,
  input  logic               t_cfg_req,
  output logic               t_cfg_ack,
  input  logic [7:0]         mode,
  output logic               i_0_req,
  input  logic               i_0_ack,
  output logic [2*WIDTH-1:0] i_0_dat,
  output logic               i_0_last,
  output logic               i_0_half
);

  fun_mode_e        mode_q, mode_d;
  logic             cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic               ofree;
  logic               pack;
  logic               store_only;
  logic               fire;
  logic               flush;
  logic               load;
  logic [2*WIDTH-1:0] ld_dat;
  logic               ld_last;
  logic               ld_half;

  // Only the pack bit of the configuration word matters
  logic unused_mode;
  assign unused_mode = ^mode[7:1];

  // Accept / flush decode; a lone non-final pack beat goes to lo_q and
  // therefore does not need the output slice to be free
  always_comb begin
    pack       = (mode_q == FUN_PACK);
    store_only = pack & ~cnt_q & ~t_0_last;
    t_0_ack    = reset_n & ~t_cfg_req & (ofree | store_only);
    fire       = t_0_req & t_0_ack;
    flush      = t_cfg_req & cnt_q & ofree;
    load       = flush | (fire & ~store_only);
    t_cfg_ack  = reset_n & t_cfg_req & ~cnt_q & ~i_0_req;
  end

  // Output word assembly; first beat always sits in the low lane
  always_comb begin
    ld_dat  = {{WIDTH{1'b0}}, t_0_dat};
    ld_last = t_0_last;
    ld_half = 1'b1;
    if (flush) begin
      ld_dat  = {{WIDTH{1'b0}}, lo_q};
      ld_last = 1'b0;
    end else if (pack && cnt_q) begin
      ld_dat  = {t_0_dat, lo_q};
      ld_half = 1'b0;
    end
  end

  // Next-state for mode, beat count and the held low beat
  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    lo_d   = lo_q;
    if (t_cfg_ack) begin
      mode_d = fun_mode_e'(mode[MODE_PACK_BIT]);
    end
    if (flush) begin
      cnt_d = 1'b0;
    end else if (fire && store_only) begin
      cnt_d = 1'b1;
      lo_d  = t_0_dat;
    end else if (fire && cnt_q) begin
      cnt_d = 1'b0;
    end
  end

  // State registers; reset drops any partial word without flushing it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= FUN_PASS;
      cnt_q  <= 1'b0;
      lo_q   <= '0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      lo_q   <= lo_d;
    end
  end

  unfunnel_oreg #(
    .DW (2 * WIDTH)
  ) u_oreg (
    .clk           (clk),
    .reset_n       (reset_n),
    .load          (load),
    .ld_dat        (ld_dat),
    .ld_last       (ld_last),
    .ld_half       (ld_half),
    .ack           (i_0_ack),
    .req           (i_0_req),
    .dat           (i_0_dat),
    .last          (i_0_last),
    .half          (i_0_half),
    .oreg_can_take (ofree)
  );

endmodule

// File: tb/tb_unfunnel_1_2.sv
// Directed, table-driven bench for unfunnel_1_2 (WIDTH = 32).
module tb_unfunnel_1_2;

  logic        clk;
  logic        reset_n;
  logic        t_0_req;
  logic        t_0_ack;
  logic [31:0] t_0_dat;
  logic        t_0_last;
  logic        t_cfg_req;
  logic        t_cfg_ack;
  logic [7:0]  mode;
  logic        i_0_req;
  logic        i_0_ack;
  logic [63:0] i_0_dat;
  logic        i_0_last;
  logic        i_0_half;

  int n_checks = 0;
  int n_passed = 0;

  unfunnel_1_2 #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .t_0_req   (t_0_req),
    .t_0_ack   (t_0_ack),
    .t_0_dat   (t_0_dat),
    .t_0_last  (t_0_last),
    .t_cfg_req (t_cfg_req),
    .t_cfg_ack (t_cfg_ack),
    .mode      (mode),
    .i_0_req   (i_0_req),
    .i_0_ack   (i_0_ack),
    .i_0_dat   (i_0_dat),
    .i_0_last  (i_0_last),
    .i_0_half  (i_0_half)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle: inputs applied, outputs expected before the next rising edge
  typedef struct {
    logic        req;
    logic [31:0] dat;
    logic        last;
    logic        cfg;
    logic [7:0]  mode;
    logic        ack;
    logic        e_tack;
    logic        e_cack;
    logic        e_oreq;
    logic [63:0] e_odat;
    logic        e_olast;
    logic        e_ohalf;
  } vec_t;

  localparam int NV = 28;
  vec_t vt [NV];

  function automatic vec_t mk(input logic req, input logic [31:0] dat, input logic last,
                              input logic cfg, input logic [7:0] md, input logic ack,
                              input logic tack, input logic cack, input logic oreq,
                              input logic [63:0] odat, input logic olast,
                              input logic ohalf);
    vec_t v;
    v.req = req;   v.dat = dat;     v.last = last;   v.cfg = cfg;
    v.mode = md;   v.ack = ack;     v.e_tack = tack; v.e_cack = cack;
    v.e_oreq = oreq; v.e_odat = odat; v.e_olast = olast; v.e_ohalf = ohalf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic req, input logic [31:0] dat, input logic last,
                       input logic cfg, input logic [7:0] md, input logic ack);
    t_0_req = req; t_0_dat = dat; t_0_last = last;
    t_cfg_req = cfg; mode = md; i_0_ack = ack;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".t_0_ack"},   {63'd0, t_0_ack},   64'd0);
    chk({tag, ".t_cfg_ack"}, {63'd0, t_cfg_ack}, 64'd0);
    chk({tag, ".i_0_req"},   {63'd0, i_0_req},   64'd0);
    chk({tag, ".i_0_dat"},   i_0_dat,            64'd0);
    chk({tag, ".i_0_last"},  {63'd0, i_0_last},  64'd0);
    chk({tag, ".i_0_half"},  {63'd0, i_0_half},  64'd0);
  endtask

  initial begin
    // Pass mode, ack tied high
    vt[0]  = mk(1, 32'h11, 0, 0, 0, 1,  1, 0, 0, 64'h0, 0, 0);
    vt[1]  = mk(1, 32'h22, 0, 0, 0, 1,  1, 0, 1, 64'h11, 0, 1);
    vt[2]  = mk(1, 32'h33, 1, 0, 0, 1,  1, 0, 1, 64'h22, 0, 1);
    vt[3]  = mk(0, 32'h0,  0, 0, 0, 1,  1, 0, 1, 64'h33, 1, 1);
    // Switch to pack
    vt[4]  = mk(0, 32'h0,  0, 1, 1, 1,  0, 1, 0, 64'h0, 0, 0);
    // Pack pair A,B
    vt[5]  = mk(1, 32'hA,  0, 0, 0, 1,  1, 0, 0, 64'h0, 0, 0);
    vt[6]  = mk(1, 32'hB,  1, 0, 0, 1,  1, 0, 0, 64'h0, 0, 0);
    vt[7]  = mk(0, 32'h0,  0, 0, 0, 1,  1, 0, 1, 64'h0000000B_0000000A, 1, 0);
    // Odd packet
    vt[8]  = mk(1, 32'h5,  1, 0, 0, 1,  1, 0, 0, 64'h0, 0, 0);
    vt[9]  = mk(0, 32'h0,  0, 0, 0, 1,  1, 0, 1, 64'h5, 1, 1);
    // Backpressure, ack low five cycles
    vt[10] = mk(1, 32'h1,  0, 0, 0, 0,  1, 0, 0, 64'h0, 0, 0);
    vt[11] = mk(1, 32'h2,  0, 0, 0, 0,  1, 0, 0, 64'h0, 0, 0);
    vt[12] = mk(1, 32'h3,  0, 0, 0, 0,  1, 0, 1, 64'h00000002_00000001, 0, 0);
    vt[13] = mk(1, 32'h4,  1, 0, 0, 0,  0, 0, 1, 64'h00000002_00000001, 0, 0);
    vt[14] = mk(1, 32'h4,  1, 0, 0, 0,  0, 0, 1, 64'h00000002_00000001, 0, 0);
    vt[15] = mk(1, 32'h4,  1, 0, 0, 1,  1, 0, 1, 64'h00000002_00000001, 0, 0);
    vt[16] = mk(0, 32'h0,  0, 0, 0, 1,  1, 0, 1, 64'h00000004_00000003, 1, 0);
    // Reconfigure to pass with a partial word held
    vt[17] = mk(1, 32'h7,  0, 0, 0, 1,  1, 0, 0, 64'h0, 0, 0);
    vt[18] = mk(1, 32'h8,  0, 1, 0, 0,  0, 0, 0, 64'h0, 0, 0);
    vt[19] = mk(1, 32'h8,  0, 1, 0, 0,  0, 0, 1, 64'h7, 0, 1);
    vt[20] = mk(1, 32'h8,  0, 1, 0, 1,  0, 0, 1, 64'h7, 0, 1);
    vt[21] = mk(1, 32'h8,  0, 1, 0, 1,  0, 1, 0, 64'h0, 0, 0);
    vt[22] = mk(1, 32'h8,  0, 0, 0, 1,  1, 0, 0, 64'h0, 0, 0);
    vt[23] = mk(0, 32'h0,  0, 0, 0, 1,  1, 0, 1, 64'h8, 0, 1);
    // Back to pack (upper mode bits ignored), leave a word pending and lo_q full
    vt[24] = mk(0, 32'h0,  0, 1, 8'h03, 1, 0, 1, 0, 64'h0, 0, 0);
    vt[25] = mk(1, 32'h9,  0, 0, 0, 0,  1, 0, 0, 64'h0, 0, 0);
    vt[26] = mk(1, 32'hA,  0, 0, 0, 0,  1, 0, 0, 64'h0, 0, 0);
    vt[27] = mk(1, 32'hC,  0, 0, 0, 0,  1, 0, 1, 64'h0000000A_00000009, 0, 0);

    // Reset state, with requests asserted
    reset_n = 1'b0;
    drive(1, 32'hFF, 0, 1, 1, 1);
    @(negedge clk);
    #2;
    chk_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 32'h0, 0, 0, 0, 1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].req, vt[i].dat, vt[i].last, vt[i].cfg, vt[i].mode, vt[i].ack);
      #2;
      chk($sformatf("v%0d.t_0_ack", i),   {63'd0, t_0_ack},   {63'd0, vt[i].e_tack});
      chk($sformatf("v%0d.t_cfg_ack", i), {63'd0, t_cfg_ack}, {63'd0, vt[i].e_cack});
      chk($sformatf("v%0d.i_0_req", i),   {63'd0, i_0_req},   {63'd0, vt[i].e_oreq});
      if (vt[i].e_oreq) begin
        chk($sformatf("v%0d.i_0_dat", i),  i_0_dat,            vt[i].e_odat);
        chk($sformatf("v%0d.i_0_last", i), {63'd0, i_0_last},  {63'd0, vt[i].e_olast});
        chk($sformatf("v%0d.i_0_half", i), {63'd0, i_0_half},  {63'd0, vt[i].e_ohalf});
      end
    end

    // Reset mid-packet: lo_q holds 0xC and a word is pending
    @(negedge clk);
    reset_n = 1'b0;
    drive(1, 32'hC, 0, 1, 0, 0);
    #2;
    chk_zero("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 32'hD, 0, 0, 0, 1);
    #2;
    chk("post.t_0_ack", {63'd0, t_0_ack}, 64'd1);
    chk("post.i_0_req0", {63'd0, i_0_req}, 64'd0);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 0, 1);
    #2;
    chk("post.i_0_req", {63'd0, i_0_req}, 64'd1);
    chk("post.i_0_dat", i_0_dat, 64'h0000000D);
    chk("post.i_0_half", {63'd0, i_0_half}, 64'd1);
    chk("post.i_0_last", {63'd0, i_0_last}, 64'd0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
